// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory-port arbiter: FSM states, owner tags
// and the width of the response-timeout counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way pick between fetch and data requesters.
// RR_EN=0: data always wins a tie; RR_EN=1: the requester not served last wins.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic   i_en,
    input  logic   i_if_req,
    input  logic   i_d_req,
    input  owner_e i_last_owner,
    output logic   o_if_gnt,
    output logic   o_d_gnt
);

    always_comb begin
        o_if_gnt = 1'b0;
        o_d_gnt  = 1'b0;
        if (i_en) begin
            if (i_if_req && i_d_req) begin
                if (RR_EN && (i_last_owner == OWN_D)) begin
                    o_if_gnt = 1'b1;
                end else begin
                    o_d_gnt = 1'b1;
                end
            end else begin
                o_if_gnt = i_if_req;
                o_d_gnt  = i_d_req;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one handshaked memory port between instruction fetch and data access,
// one transaction outstanding. Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic                o_if_gnt,
    output logic                o_if_valid,
    output logic [DATA_W-1:0]   o_if_rdata,
    input  logic                i_d_req,
    input  logic                i_d_wen,
    input  logic [ADDR_W-1:0]   i_d_addr,
    input  logic [DATA_W-1:0]   i_d_wdata,
    input  logic [DATA_W/8-1:0] i_d_mask,
    output logic                o_d_gnt,
    output logic                o_d_valid,
    output logic [DATA_W-1:0]   o_d_rdata,
    output logic                o_mem_req,
    output logic                o_mem_wen,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_mask,
    input  logic                i_mem_ready,
    input  logic                i_mem_valid,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_timeout
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_e             state_q, state_d;
    owner_e                 owner_q, owner_d;
    logic                   wen_q, wen_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [MASK_W-1:0]      mask_q, mask_d;
    logic [TMO_CNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic                   tmo_hit;
    logic                   rsp_vld;
    logic [DATA_W-1:0]      rsp_data;
    logic                   if_gnt, d_gnt;
    owner_e                 last_owner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
    owner_e last_owner_q, last_owner_d;

    always_comb begin
        last_owner_d = last_owner_q;
        if (if_gnt || d_gnt) begin
            last_owner_d = d_gnt ? OWN_D : OWN_IF;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_owner_q <= OWN_IF;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    assign last_owner = last_owner_q;
`else
    localparam bit RR_EN = 1'b0;
    assign last_owner = OWN_IF;
`endif

    // Grants are gated by reset so no gnt leaks out while the block is held in reset.
    mem_arb_pick #(
        .RR_EN(RR_EN)
    ) u_pick (
        .i_en        ((state_q == IDLE) && i_rst_n),
        .i_if_req    (i_if_req),
        .i_d_req     (i_d_req),
        .i_last_owner(last_owner),
        .o_if_gnt    (if_gnt),
        .o_d_gnt     (d_gnt)
    );

    assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt_q == TMO_CNT_W'(TIMEOUT));

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mask_d    = mask_q;
        tmo_cnt_d = tmo_cnt_q;
        rsp_vld   = 1'b0;
        rsp_data  = '0;
        o_timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_gnt) begin
                    state_d = REQ;
                    owner_d = OWN_D;
                    wen_d   = i_d_wen;
                    addr_d  = i_d_addr;
                    wdata_d = i_d_wdata;
                    mask_d  = i_d_mask;
                end else if (if_gnt) begin
                    state_d = REQ;
                    owner_d = OWN_IF;
                    wen_d   = 1'b0;
                    addr_d  = i_if_addr;
                    wdata_d = '0;
                    mask_d  = '1;
                end
            end
            REQ: begin
                if (i_mem_ready) begin
                    state_d   = WAIT_RSP;
                    tmo_cnt_d = '0;
                end
            end
            WAIT_RSP: begin
                // Saturating count: an unbounded wait (TIMEOUT=0) must never wrap.
                if (tmo_cnt_q != '1) begin
                    tmo_cnt_d = tmo_cnt_q + TMO_CNT_W'(1);
                end
                if (i_mem_valid) begin
                    rsp_vld  = 1'b1;
                    rsp_data = i_mem_rdata;
                    state_d  = IDLE;
                end else if (tmo_hit) begin
                    rsp_vld   = 1'b1;
                    o_timeout = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_if_gnt    = if_gnt;
    assign o_d_gnt     = d_gnt;
    assign o_if_valid  = rsp_vld && (owner_q == OWN_IF);
    assign o_d_valid   = rsp_vld && (owner_q == OWN_D);
    assign o_if_rdata  = o_if_valid ? rsp_data : '0;
    assign o_d_rdata   = o_d_valid ? rsp_data : '0;
    assign o_mem_req   = (state_q == REQ);
    assign o_mem_wen   = wen_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_mask  = mask_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IF;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mask_q    <= '0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mask_q    <= mask_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a transaction-level model.
module tb_mem_port_arbiter;

    localparam int TMO = 4;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_valid;
    logic [31:0] if_rdata;
    logic        d_req, d_wen;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_mask;
    logic        d_gnt, d_valid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_mask;
    logic        mem_ready, mem_valid;
    logic [31:0] mem_rdata;
    logic        timeout;

    int n_checks = 0;
    int n_err    = 0;

    // Model state: pending requests per requester and who was served last.
    bit          pend_if, pend_d, last_d;
    logic [31:0] p_if_addr, p_d_addr, p_d_wdata;
    logic        p_d_wen;
    logic [3:0]  p_d_mask;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
        .o_if_valid(if_valid), .o_if_rdata(if_rdata),
        .i_d_req(d_req), .i_d_wen(d_wen), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .i_d_mask(d_mask), .o_d_gnt(d_gnt), .o_d_valid(d_valid), .o_d_rdata(d_rdata),
        .o_mem_req(mem_req), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_mask(mem_mask),
        .i_mem_ready(mem_ready), .i_mem_valid(mem_valid), .i_mem_rdata(mem_rdata),
        .o_timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        if_req  = pend_if;
        if_addr = p_if_addr;
        d_req   = pend_d;
        d_wen   = p_d_wen;
        d_addr  = p_d_addr;
        d_wdata = p_d_wdata;
        d_mask  = p_d_mask;
    endtask

    // One full transaction from an IDLE cycle: ready after rdy_dly REQ cycles,
    // response on WAIT_RSP cycle vld_dly (beyond TMO means the timeout fires).
    task automatic serve(input int rdy_dly, input int vld_dly, input logic [31:0] rdata);
        bit          win_d, done;
        logic [31:0] e_addr, e_wdata;
        logic        e_wen;
        logic [3:0]  e_mask;
        win_d = pend_d && !(pend_if && RR && last_d);
        drive_reqs();
        mem_ready = 1'b0;
        mem_valid = 1'($urandom_range(0, 1));
        #1;
        chk("idle_if_gnt", if_gnt, pend_if && !win_d);
        chk("idle_d_gnt", d_gnt, win_d);
        chk("idle_mem_req", mem_req, 1'b0);
        chk("idle_valid", {if_valid, d_valid}, 2'b00);
        e_wen   = win_d ? p_d_wen : 1'b0;
        e_addr  = win_d ? p_d_addr : p_if_addr;
        e_wdata = p_d_wdata;
        e_mask  = p_d_mask;
        last_d  = win_d;
        @(negedge clk);
        if (win_d) begin
            pend_d    = 1'b0;
            p_d_addr  = $urandom;
            p_d_wdata = $urandom;
            p_d_mask  = 4'($urandom);
            p_d_wen   = 1'($urandom);
        end else begin
            pend_if   = 1'b0;
            p_if_addr = $urandom;
        end
        drive_reqs();
        for (int r = 0; r <= rdy_dly; r++) begin
            mem_ready = (r == rdy_dly);
            mem_valid = 1'($urandom_range(0, 1));
            #1;
            chk("req_mem_req", mem_req, 1'b1);
            chk("req_wen", mem_wen, e_wen);
            chk("req_addr", mem_addr, e_addr);
            if (win_d) begin
                chk("req_wdata", mem_wdata, e_wdata);
                chk("req_mask", mem_mask, e_mask);
            end
            chk("req_gnt", {if_gnt, d_gnt}, 2'b00);
            chk("req_valid", {if_valid, d_valid}, 2'b00);
            @(negedge clk);
        end
        done = 1'b0;
        for (int w = 0; w <= TMO && !done; w++) begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            if (w == vld_dly) begin
                mem_valid = 1'b1;
                mem_rdata = rdata;
                #1;
                chk("rsp_own_valid", win_d ? d_valid : if_valid, 1'b1);
                chk("rsp_oth_valid", win_d ? if_valid : d_valid, 1'b0);
                chk("rsp_rdata", win_d ? d_rdata : if_rdata, rdata);
                chk("rsp_no_tmo", timeout, 1'b0);
                done = 1'b1;
            end else if (w == TMO) begin
                mem_valid = 1'b0;
                #1;
                chk("tmo_pulse", timeout, 1'b1);
                chk("tmo_own_valid", win_d ? d_valid : if_valid, 1'b1);
                chk("tmo_oth_valid", win_d ? if_valid : d_valid, 1'b0);
                chk("tmo_rdata", win_d ? d_rdata : if_rdata, 32'h0);
                done = 1'b1;
            end else begin
                mem_valid = 1'b0;
                #1;
                chk("wait_valid", {if_valid, d_valid, timeout}, 3'b000);
                chk("wait_mem_req", mem_req, 1'b0);
                chk("wait_gnt", {if_gnt, d_gnt}, 2'b00);
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        mem_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        pend_if = 1'b0; pend_d = 1'b0; last_d = 1'b0;
        p_if_addr = '0; p_d_addr = '0; p_d_wdata = '0; p_d_wen = 1'b0; p_d_mask = '0;
        drive_reqs();
        mem_ready = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", {if_gnt, d_gnt}, 2'b00);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_valid", {if_valid, d_valid, timeout}, 3'b000);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fetch only, minimum latency.
        pend_if = 1'b1; p_if_addr = 32'h100;
        serve(0, 0, 32'h0010_0073);

        // Tie, then a second tie while fetch is still pending.
        pend_if = 1'b1; p_if_addr = 32'h180;
        pend_d = 1'b1; p_d_wen = 1'b0; p_d_addr = 32'h2000; p_d_wdata = '0; p_d_mask = 4'hf;
        serve(0, 1, 32'hCAFE_0001);
        pend_d = 1'b1; p_d_wen = 1'b0; p_d_addr = 32'h2004; p_d_mask = 4'hf;
        serve(1, 0, 32'hCAFE_0002);
        serve(0, 0, 32'hCAFE_0003);

        // Byte write.
        pend_d = 1'b1; p_d_wen = 1'b1; p_d_addr = 32'h2003; p_d_wdata = 32'hAB00_0000;
        p_d_mask = 4'b1000;
        serve(0, 2, 32'h0);

        // Backpressure with the other requester waiting.
        pend_d = 1'b1; p_d_wen = 1'b0; p_d_addr = 32'h4000; p_d_mask = 4'hf;
        pend_if = 1'b1; p_if_addr = 32'h500;
        serve(10, 0, 32'h1234_5678);
        serve(0, 0, 32'h8765_4321);

        // Timeout, then a response exactly on the timeout cycle.
        pend_if = 1'b1; p_if_addr = 32'h600;
        serve(0, 99, 32'h0);
        pend_if = 1'b1; p_if_addr = 32'h604;
        serve(0, TMO, 32'h5A5A_A5A5);

        // Asynchronous reset while waiting for a response.
        pend_if = 1'b1; p_if_addr = 32'h700;
        drive_reqs();
        @(negedge clk);
        pend_if = 1'b0;
        drive_reqs();
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        mem_valid = 1'b1;
        #1;
        chk("arst_mem_req", mem_req, 1'b0);
        chk("arst_valid", {if_valid, d_valid, timeout}, 3'b000);
        chk("arst_mem_addr", mem_addr, 32'h0);
        chk("arst_gnt", {if_gnt, d_gnt}, 2'b00);
        @(negedge clk);
        mem_valid = 1'b0;
        rst_n = 1'b1;
        last_d = 1'b0;
        @(negedge clk);
        pend_d = 1'b1; p_d_wen = 1'b0; p_d_addr = 32'h800; p_d_mask = 4'hf;
        serve(0, 0, 32'h0BAD_F00D);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            if (!pend_if && ($urandom_range(0, 1) == 1)) begin
                pend_if = 1'b1;
                p_if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!pend_d && ($urandom_range(0, 1) == 1)) begin
                pend_d    = 1'b1;
                p_d_wen   = 1'($urandom);
                p_d_addr  = $urandom & 32'hFFFF_FFFC;
                p_d_wdata = $urandom;
                p_d_mask  = 4'($urandom);
            end
            if (!pend_if && !pend_d) begin
                drive_reqs();
                #1;
                chk("rnd_idle_gnt", {if_gnt, d_gnt}, 2'b00);
                @(negedge clk);
            end else begin
                serve($urandom_range(0, 3), $urandom_range(0, 6), $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
